// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator feeding a registered 2-entry skid buffer.
// Format is taken from ext_op (DECODE_MODE=0) or from an opcode/funct3 decode (DECODE_MODE=1).
module imm_gen_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DECODE_MODE = 1,
  parameter int unsigned TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [6:0]       ext_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [6:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [6:0] F_ZIMM  = 7'b1000000;
  localparam logic [6:0] F_SHAMT = 7'b0100000;
  localparam logic [6:0] F_I     = 7'b0010000;
  localparam logic [6:0] F_S     = 7'b0001000;
  localparam logic [6:0] F_B     = 7'b0000100;
  localparam logic [6:0] F_U     = 7'b0000010;
  localparam logic [6:0] F_J     = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [6:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [5:0]      shamt;
  logic [6:0]      fmt;
  logic            err;
  logic [XLEN-1:0] imm;
  entry_t          new_e;
  entry_t          main_q;
  entry_t          skid_q;
  logic            main_valid;
  logic            skid_valid;
  logic            accept;
  logic            drain;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    fmt = '0;
    err = 1'b0;
    if (DECODE_MODE == 0) begin
      // x & (x-1) is nonzero exactly when more than one bit is set
      if ((ext_op & (ext_op - 7'd1)) != '0) err = 1'b1;
      else                                  fmt = ext_op;
    end else begin
      case (opc)
        7'b0010011:             fmt = (f3 == 3'b001 || f3 == 3'b101) ? F_SHAMT : F_I;
        7'b0000011, 7'b1100111: fmt = F_I;
        7'b0100011:             fmt = F_S;
        7'b1100011:             fmt = F_B;
        7'b0110111, 7'b0010111: fmt = F_U;
        7'b1101111:             fmt = F_J;
        7'b1110011:             fmt = f3[2] ? F_ZIMM : F_I;
        7'b0110011:             fmt = '0;
        default:                err = 1'b1;
      endcase
    end
  end

  always_comb begin
    imm = '0;
    case (fmt)
      F_SHAMT: imm = XLEN'(shamt);
      F_I:     imm = sext({{20{in_instr[31]}}, in_instr[31:20]});
      F_S:     imm = sext({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      F_B:     imm = sext({{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
      F_U:     imm = sext({in_instr[31:12], 12'b0});
      F_J:     imm = sext({{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
      F_ZIMM:  imm = XLEN'(in_instr[19:15]);
      default: imm = '0;
    endcase
  end

  always_comb begin
    new_e     = '0;
    new_e.imm = imm;
    new_e.fmt = fmt;
    new_e.tag = in_tag;
    new_e.err = err;
  end

  assign accept = in_valid && !skid_valid;
  assign drain  = main_valid && out_ready;

  // Skid is only ever filled while main is occupied and stalled, so it always holds the younger entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (drain) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid || drain) begin
        main_q     <= new_e;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= new_e;
        skid_valid <= 1'b1;
      end
    end else if (drain) begin
      main_valid <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_imm   = main_q.imm;
  assign out_fmt   = main_q.fmt;
  assign out_tag   = main_q.tag;
  assign out_err   = main_q.err;

endmodule
